// File: rtl/hist_fsm_2stage.sv
// rtl/hist_fsm_2stage.sv - two-stage coarse/fine TDC histogram peak finder
//
// Purpose: bins ACQ_NUM TDC codes on their top CB_W bits, scans for the
// coarse peak, then bins a second ACQ_NUM codes on the next FB_W bits,
// keeping only codes whose coarse field matches the coarse peak, and scans
// for the fine peak. Result is tof = {peakCH, peakFH}.
//
// Optional feature macro: MIN_PEAK_EN (adds minPeak input / peakValid output;
// a coarse peak below minPeak skips the fine phase).
//
// Ports:
//   clk, res          clock, asynchronous active-high reset
//   start             one-cycle frame start (honoured only when idle)
//   wrEn, data        TDC event strobe and code
//   busy              frame in progress
//   hisNum            0 = coarse phase, 1 = fine phase
//   acq_count_finish  pulse on the last accepted event of a phase
//   peakCH, peakFH    coarse / fine peak bins
//   peakCnt           fine peak count
//   tof               {peakCH, peakFH}
//   peakDone          one-cycle pulse when results are valid
//   minPeak, peakValid  (MIN_PEAK_EN only)

module hist_fsm_2stage #(
    parameter int TDC_W   = 10,
    parameter int CB_W    = 5,
    parameter int FB_W    = 5,
    parameter int CNT_W   = 8,
    parameter int ACQ_NUM = 16
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  start,
    input  logic                  wrEn,
    input  logic [TDC_W-1:0]      data,
`ifdef MIN_PEAK_EN
    input  logic [CNT_W-1:0]      minPeak,
    output logic                  peakValid,
`endif
    output logic                  busy,
    output logic                  hisNum,
    output logic                  acq_count_finish,
    output logic [CB_W-1:0]       peakCH,
    output logic [FB_W-1:0]       peakFH,
    output logic [CNT_W-1:0]      peakCnt,
    output logic [CB_W+FB_W-1:0]  tof,
    output logic                  peakDone
);

    localparam int IDX_W = (CB_W > FB_W) ? CB_W : FB_W;
    localparam int DEPTH = 1 << IDX_W;
    localparam int EV_W  = $clog2(ACQ_NUM + 1);
    localparam logic [IDX_W-1:0] C_LAST  = IDX_W'((1 << CB_W) - 1);
    localparam logic [IDX_W-1:0] F_LAST  = IDX_W'((1 << FB_W) - 1);
    localparam logic [EV_W-1:0]  EV_LAST = EV_W'(ACQ_NUM - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {IDLE, ACQ_C, SCAN_C, ACQ_F, SCAN_F, DONE} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0] hist [DEPTH];
    logic [EV_W-1:0]  ev_cnt;
    logic [IDX_W-1:0] scan_idx, max_idx, cand_idx, wr_idx;
    logic [CNT_W-1:0] max_cnt, cand_cnt, rd_cnt;
    logic [CB_W-1:0]  cbin;
    logic [FB_W-1:0]  fbin;
    logic             acq, scan, hit, ev_last, c_end, f_end, skip_fine;

    assign cbin = data[TDC_W-1 -: CB_W];
    assign fbin = data[TDC_W-CB_W-1 -: FB_W];
    assign tof  = {peakCH, peakFH};

    // Running maximum including the entry read this cycle; strict '>' keeps
    // the lowest index on ties and yields index 0 for an empty histogram.
    assign rd_cnt   = hist[scan_idx];
    assign cand_cnt = (rd_cnt > max_cnt) ? rd_cnt   : max_cnt;
    assign cand_idx = (rd_cnt > max_cnt) ? scan_idx : max_idx;
    assign wr_idx   = (state == ACQ_F) ? IDX_W'(fbin) : IDX_W'(cbin);
    assign ev_last  = (ev_cnt == EV_LAST);

    always_comb begin
        state_nxt        = state;
        busy             = 1'b0;
        hisNum           = 1'b0;
        peakDone         = 1'b0;
        acq_count_finish = 1'b0;
        acq              = 1'b0;
        scan             = 1'b0;
        hit              = 1'b0;
        c_end            = 1'b0;
        f_end            = 1'b0;
        skip_fine        = 1'b0;
`ifdef MIN_PEAK_EN
        skip_fine        = (cand_cnt < minPeak);
`endif
        case (state)
            IDLE: begin
                if (start) state_nxt = ACQ_C;
            end
            ACQ_C: begin
                busy = 1'b1;
                acq  = 1'b1;
                hit  = wrEn;
                if (wrEn && ev_last) begin
                    acq_count_finish = 1'b1;
                    state_nxt        = SCAN_C;
                end
            end
            SCAN_C: begin
                busy  = 1'b1;
                scan  = 1'b1;
                c_end = (scan_idx == C_LAST);
                if (c_end) state_nxt = skip_fine ? DONE : ACQ_F;
            end
            ACQ_F: begin
                busy   = 1'b1;
                hisNum = 1'b1;
                acq    = 1'b1;
                // Out-of-window events still count toward the phase length.
                hit    = wrEn && (cbin == peakCH);
                if (wrEn && ev_last) begin
                    acq_count_finish = 1'b1;
                    state_nxt        = SCAN_F;
                end
            end
            SCAN_F: begin
                busy   = 1'b1;
                hisNum = 1'b1;
                scan   = 1'b1;
                f_end  = (scan_idx == F_LAST);
                if (f_end) state_nxt = DONE;
            end
            DONE: begin
                peakDone  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state    <= IDLE;
            for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
            ev_cnt   <= '0;
            scan_idx <= '0;
            max_idx  <= '0;
            max_cnt  <= '0;
            peakCH   <= '0;
            peakFH   <= '0;
            peakCnt  <= '0;
`ifdef MIN_PEAK_EN
            peakValid <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (acq && wrEn) ev_cnt <= ev_last ? '0 : ev_cnt + 1'b1;
            if (hit && (hist[wr_idx] != CNT_MAX)) hist[wr_idx] <= hist[wr_idx] + 1'b1;
            if (scan) begin
                // Clearing on read leaves the file empty for the next phase.
                hist[scan_idx] <= '0;
                if (c_end || f_end) begin
                    scan_idx <= '0;
                    max_idx  <= '0;
                    max_cnt  <= '0;
                end else begin
                    scan_idx <= scan_idx + 1'b1;
                    max_idx  <= cand_idx;
                    max_cnt  <= cand_cnt;
                end
            end
            if (c_end) begin
                peakCH <= cand_idx[CB_W-1:0];
`ifdef MIN_PEAK_EN
                if (skip_fine) begin
                    peakFH    <= '0;
                    peakCnt   <= '0;
                    peakValid <= 1'b0;
                end
`endif
            end
            if (f_end) begin
                peakFH  <= cand_idx[FB_W-1:0];
                peakCnt <= cand_cnt;
`ifdef MIN_PEAK_EN
                peakValid <= 1'b1;
`endif
            end
        end
    end

endmodule
